// File: rtl/fsic_clock_div_ctrl.sv
// Programmable clock divider for the FSIC clock tree: ratio handshake, phase-aligned ratio switch, gate-high parking.
// Optional FSIC_CLOCK_ODD_DIV_EN enables odd ratios with an asymmetric (N+1)/2 high, (N-1)/2 low phase split.
module fsic_clock_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             gate_req,
    output logic             gate_ack,
    output logic             div_clk,
    output logic             div_tick,
    output logic [CNT_W-1:0] cur_div,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_GATED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEFAULT_DIV_V = CNT_W'(DEFAULT_DIV);

    // Terminal count of the low phase: H-1 with H = floor(N/2).
    function automatic logic [CNT_W-1:0] low_term(input logic [CNT_W-1:0] n);
        return (n >> 1) - CNT_W'(1);
    endfunction

    // Terminal count of the high phase; odd ratios get the extra cycle in the high phase.
    function automatic logic [CNT_W-1:0] high_term(input logic [CNT_W-1:0] n);
`ifdef FSIC_CLOCK_ODD_DIV_EN
        if (n[0]) begin
            return n >> 1;
        end else begin
            return low_term(n);
        end
`else
        return low_term(n);
`endif
    endfunction

    function automatic logic ratio_legal(input logic [CNT_W-1:0] n);
`ifdef FSIC_CLOCK_ODD_DIV_EN
        return (n >= CNT_W'(2));
`else
        return (n >= CNT_W'(2)) && !n[0];
`endif
    endfunction

    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [CNT_W-1:0] cur_div_r, cur_div_next_s;
    logic [CNT_W-1:0] pend_div_r, pend_div_next_s;
    logic             div_clk_r, div_clk_next_s;
    logic             div_tick_r, div_tick_next_s;
    logic             cfg_ready_r, cfg_ready_next_s;
    logic             cfg_err_r, cfg_err_next_s;
    logic             busy_r, busy_next_s;
    logic             gate_ack_r, gate_ack_next_s;

    logic [CNT_W-1:0] term_s;
    logic             toggle_s;
    logic             accept_s;
    logic             legal_s;
    logic             rise_s;
    logic             fall_s;

    // Phase bookkeeping shared by next-state and datapath logic.
    always_comb begin
        term_s   = div_clk_r ? high_term(cur_div_r) : low_term(cur_div_r);
        toggle_s = (cnt_r >= term_s);
        rise_s   = toggle_s && !div_clk_r;
        fall_s   = toggle_s && div_clk_r;
        accept_s = cfg_valid && cfg_ready_r;
        legal_s  = ratio_legal(cfg_div);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a ratio accept in RUN wins over a gate request.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (accept_s && legal_s) begin
                    state_next_s = ST_PEND;
                end else if (gate_req && rise_s) begin
                    state_next_s = ST_GATED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_PEND: begin
                if (fall_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_PEND;
                end
            end
            ST_GATED: begin
                if (!gate_req) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_GATED;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Output and datapath next values; new ratios only land with the counter at 0 so no phase is truncated.
    always_comb begin
        cnt_next_s      = cnt_r;
        div_clk_next_s  = div_clk_r;
        div_tick_next_s = 1'b0;
        cur_div_next_s  = cur_div_r;
        pend_div_next_s = pend_div_r;
        cfg_err_next_s  = accept_s && !legal_s;
        case (state_r)
            ST_RUN, ST_PEND: begin
                if (toggle_s) begin
                    cnt_next_s      = {CNT_W{1'b0}};
                    div_clk_next_s  = !div_clk_r;
                    div_tick_next_s = !div_clk_r;
                end else begin
                    cnt_next_s      = cnt_r + CNT_W'(1);
                end
                if (state_r == ST_PEND && fall_s) begin
                    cur_div_next_s = pend_div_r;
                end else if (state_r == ST_RUN && accept_s && legal_s) begin
                    pend_div_next_s = cfg_div;
                end else begin
                    pend_div_next_s = pend_div_r;
                end
            end
            ST_GATED: begin
                cnt_next_s     = {CNT_W{1'b0}};
                div_clk_next_s = 1'b1;
                if (accept_s && legal_s) begin
                    cur_div_next_s = cfg_div;
                end else begin
                    cur_div_next_s = cur_div_r;
                end
            end
            default: begin
                cnt_next_s     = {CNT_W{1'b0}};
                div_clk_next_s = 1'b1;
            end
        endcase
        // busy trails the load by one cycle, so cfg_ready returns the cycle after cur_div changes.
        busy_next_s      = (state_r == ST_PEND) || ((state_r == ST_RUN) && accept_s && legal_s);
        cfg_ready_next_s = !busy_next_s;
        gate_ack_next_s  = (state_next_s == ST_GATED);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r       <= {CNT_W{1'b0}};
            div_clk_r   <= 1'b1;
            div_tick_r  <= 1'b0;
            cur_div_r   <= DEFAULT_DIV_V;
            pend_div_r  <= DEFAULT_DIV_V;
            cfg_ready_r <= 1'b1;
            cfg_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            gate_ack_r  <= 1'b0;
        end else begin
            cnt_r       <= cnt_next_s;
            div_clk_r   <= div_clk_next_s;
            div_tick_r  <= div_tick_next_s;
            cur_div_r   <= cur_div_next_s;
            pend_div_r  <= pend_div_next_s;
            cfg_ready_r <= cfg_ready_next_s;
            cfg_err_r   <= cfg_err_next_s;
            busy_r      <= busy_next_s;
            gate_ack_r  <= gate_ack_next_s;
        end
    end

    assign div_clk   = div_clk_r;
    assign div_tick  = div_tick_r;
    assign cur_div   = cur_div_r;
    assign cfg_ready = cfg_ready_r;
    assign cfg_err   = cfg_err_r;
    assign busy      = busy_r;
    assign gate_ack  = gate_ack_r;

endmodule

// File: tb/tb_fsic_clock_div_ctrl.sv
// Directed self-checking bench for fsic_clock_div_ctrl; each observation is taken 1 ns after a rising edge.
module tb_fsic_clock_div_ctrl;

    logic       clk;
    logic       reset;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       gate_req;
    logic       gate_ack;
    logic       div_clk;
    logic       div_tick;
    logic [7:0] cur_div;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    fsic_clock_div_ctrl #(.CNT_W(8), .DEFAULT_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .gate_req  (gate_req),
        .gate_ack  (gate_ack),
        .div_clk   (div_clk),
        .div_tick  (div_tick),
        .cur_div   (cur_div),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at observation 0: div_clk=1, counter 0, nothing has ticked yet.
    task automatic do_reset();
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;
        gate_req  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic exp_div4(input int i);
        return ((i / 2) % 2) == 0;
    endfunction

    function automatic logic exp_tick4(input int i);
        return (i > 0) && ((i % 4) == 0);
    endfunction

    task automatic test_reset();
        reset = 1'b1; cfg_valid = 1'b0; cfg_div = 8'd0; gate_req = 1'b0;
        #1;
        checks++; if (div_clk !== 1'b1) begin failures++; $display("FAIL rst_div_clk: got %b expected 1", div_clk); end
        checks++; if (div_tick !== 1'b0) begin failures++; $display("FAIL rst_div_tick: got %b expected 0", div_tick); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_cfg_ready: got %b expected 1", cfg_ready); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rst_cfg_err: got %b expected 0", cfg_err); end
        checks++; if (gate_ack !== 1'b0) begin failures++; $display("FAIL rst_gate_ack: got %b expected 0", gate_ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (cur_div !== 8'd4) begin failures++; $display("FAIL rst_cur_div: got %0d expected 4", cur_div); end
    endtask

    task automatic test_default_div();
        do_reset();
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (div_clk !== exp_div4(i)) begin failures++; $display("FAIL div4_clk[%0d]: got %b expected %b", i, div_clk, exp_div4(i)); end
            checks++;
            if (div_tick !== exp_tick4(i)) begin failures++; $display("FAIL div4_tick[%0d]: got %b expected %b", i, div_tick, exp_tick4(i)); end
            step();
        end
        checks++; if (cur_div !== 8'd4) begin failures++; $display("FAIL div4_cur_div: got %0d expected 4", cur_div); end
    endtask

    task automatic test_change_div8();
        logic [10:0] pat;
        pat = 11'b00_1111_0000_11; // bit i = expected div_clk at observation i
        do_reset();
        cfg_valid = 1'b1; cfg_div = 8'd8;
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (div_clk !== pat[i]) begin failures++; $display("FAIL chg8_clk[%0d]: got %b expected %b", i, div_clk, pat[i]); end
            if (i == 1) begin
                cfg_valid = 1'b0;
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL chg8_busy_pend: got %b expected 1", busy); end
                checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL chg8_ready_pend: got %b expected 0", cfg_ready); end
                checks++; if (cur_div !== 8'd4) begin failures++; $display("FAIL chg8_cur_div_pend: got %0d expected 4", cur_div); end
            end
            if (i == 2) begin
                checks++; if (cur_div !== 8'd8) begin failures++; $display("FAIL chg8_cur_div_load: got %0d expected 8", cur_div); end
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL chg8_busy_load: got %b expected 1", busy); end
            end
            if (i == 3) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL chg8_busy_done: got %b expected 0", busy); end
                checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL chg8_ready_done: got %b expected 1", cfg_ready); end
            end
            if (i == 6) begin
                checks++; if (div_tick !== 1'b1) begin failures++; $display("FAIL chg8_tick: got %b expected 1", div_tick); end
            end
            step();
        end
    endtask

    task automatic test_odd_div();
        logic [9:0] pat;
`ifdef FSIC_CLOCK_ODD_DIV_EN
        pat = 10'b10_0111_0011;
`else
        pat = 10'b00_1100_1100 | 10'b00_0000_0011 | 10'b11_0000_0000;
        pat = 10'b11_0011_0011;
`endif
        do_reset();
        cfg_valid = 1'b1; cfg_div = 8'd5;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (div_clk !== pat[i]) begin failures++; $display("FAIL odd5_clk[%0d]: got %b expected %b", i, div_clk, pat[i]); end
            if (i == 1) begin
                cfg_valid = 1'b0;
`ifdef FSIC_CLOCK_ODD_DIV_EN
                checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL odd5_err: got %b expected 0", cfg_err); end
`else
                checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL odd5_err: got %b expected 1", cfg_err); end
`endif
            end
            if (i == 2) begin
                checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL odd5_err_clear: got %b expected 0", cfg_err); end
            end
            step();
        end
`ifdef FSIC_CLOCK_ODD_DIV_EN
        checks++; if (cur_div !== 8'd5) begin failures++; $display("FAIL odd5_cur_div: got %0d expected 5", cur_div); end
`else
        checks++; if (cur_div !== 8'd4) begin failures++; $display("FAIL odd5_cur_div: got %0d expected 4", cur_div); end
`endif
    endtask

    task automatic test_gate_div6();
        logic [14:0] pat;
        pat = 15'b011_1111_1110_0011;
        do_reset();
        cfg_valid = 1'b1; cfg_div = 8'd6;
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (div_clk !== pat[i]) begin failures++; $display("FAIL gate6_clk[%0d]: got %b expected %b", i, div_clk, pat[i]); end
            if (i == 1) cfg_valid = 1'b0;
            if (i == 3) gate_req = 1'b1;
            if (i == 4) begin
                checks++; if (gate_ack !== 1'b0) begin failures++; $display("FAIL gate6_ack_early: got %b expected 0", gate_ack); end
            end
            if (i == 5) begin
                checks++; if (div_tick !== 1'b1) begin failures++; $display("FAIL gate6_tick: got %b expected 1", div_tick); end
                checks++; if (gate_ack !== 1'b1) begin failures++; $display("FAIL gate6_ack: got %b expected 1", gate_ack); end
            end
            if (i == 8) begin
                checks++; if (div_tick !== 1'b0) begin failures++; $display("FAIL gate6_no_tick: got %b expected 0", div_tick); end
                checks++; if (gate_ack !== 1'b1) begin failures++; $display("FAIL gate6_ack_hold: got %b expected 1", gate_ack); end
            end
            if (i == 10) gate_req = 1'b0;
            if (i == 11) begin
                checks++; if (gate_ack !== 1'b0) begin failures++; $display("FAIL gate6_ack_drop: got %b expected 0", gate_ack); end
            end
            step();
        end
    endtask

    task automatic test_gated_cfg();
        logic [11:0] pat;
        pat = 12'b1010_1111_0011;
        do_reset();
        gate_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (div_clk !== pat[i]) begin failures++; $display("FAIL gcfg_clk[%0d]: got %b expected %b", i, div_clk, pat[i]); end
            if (i == 4) begin
                checks++; if (gate_ack !== 1'b1) begin failures++; $display("FAIL gcfg_ack: got %b expected 1", gate_ack); end
            end
            if (i == 5) begin
                cfg_valid = 1'b1; cfg_div = 8'd2;
            end
            if (i == 6) begin
                cfg_valid = 1'b0; gate_req = 1'b0;
                checks++; if (cur_div !== 8'd2) begin failures++; $display("FAIL gcfg_cur_div: got %0d expected 2", cur_div); end
                checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL gcfg_ready: got %b expected 1", cfg_ready); end
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gcfg_busy: got %b expected 0", busy); end
            end
            if (i == 9) begin
                checks++; if (div_tick !== 1'b1) begin failures++; $display("FAIL gcfg_tick: got %b expected 1", div_tick); end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cfg_valid = 1'b1; cfg_div = 8'd6; gate_req = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        step(); step(); step();
        checks++; if (gate_ack !== 1'b0) begin failures++; $display("FAIL b2b_ack_early: got %b expected 0", gate_ack); end
        checks++; if (div_clk !== 1'b0) begin failures++; $display("FAIL b2b_low: got %b expected 0", div_clk); end
        step();
        checks++; if (gate_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack: got %b expected 1", gate_ack); end
        checks++; if (div_tick !== 1'b1) begin failures++; $display("FAIL b2b_tick: got %b expected 1", div_tick); end
        checks++; if (cur_div !== 8'd6) begin failures++; $display("FAIL b2b_cur_div: got %0d expected 6", cur_div); end
        step();
        cfg_valid = 1'b1; cfg_div = 8'd0;
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL b2b_gated_err: got %b expected 1", cfg_err); end
        checks++; if (cur_div !== 8'd6) begin failures++; $display("FAIL b2b_gated_keep: got %0d expected 6", cur_div); end
        checks++; if (div_clk !== 1'b1) begin failures++; $display("FAIL b2b_gated_clk: got %b expected 1", div_clk); end
        gate_req = 1'b0;
        step();
    endtask

    task automatic test_reset_pend();
        do_reset();
        cfg_valid = 1'b1; cfg_div = 8'd10;
        step();
        cfg_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rpend_busy_before: got %b expected 1", busy); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rpend_busy: got %b expected 0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rpend_ready: got %b expected 1", cfg_ready); end
        checks++; if (div_clk !== 1'b1) begin failures++; $display("FAIL rpend_div_clk: got %b expected 1", div_clk); end
        checks++; if (cur_div !== 8'd4) begin failures++; $display("FAIL rpend_cur_div: got %0d expected 4", cur_div); end
        checks++; if (gate_ack !== 1'b0) begin failures++; $display("FAIL rpend_ack: got %b expected 0", gate_ack); end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (div_clk !== exp_div4(i)) begin failures++; $display("FAIL rpend_clk[%0d]: got %b expected %b", i, div_clk, exp_div4(i)); end
            step();
        end
        checks++; if (cur_div !== 8'd4) begin failures++; $display("FAIL rpend_cur_div_after: got %0d expected 4", cur_div); end
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_change_div8();
        test_odd_div();
        test_gate_div6();
        test_gated_cfg();
        test_back_to_back();
        test_reset_pend();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
